// File: rtl/matmul_pkg.sv
// Shared state encodings and width helpers for the matrix-multiply engine.
package matmul_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RUN   = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // Width of a counter/address covering v entries; never narrower than 1 bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Accumulator wide enough for k worst-case products of two data_w operands.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned k);
    return 2 * data_w + $clog2(k + 1);
  endfunction

endpackage

// File: rtl/matmul_engine_mac_lane.sv
// One multiply-accumulate lane: acc += a*b with per-job signed/unsigned operands.
module mac_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  // Product is formed modulo 2^ACC_W; the true sum always fits, so this is exact.
  always_comb begin
    if (signed_mode) begin
      a_ext = ACC_W'($signed(a));
      b_ext = ACC_W'($signed(b));
    end else begin
      a_ext = ACC_W'(a);
      b_ext = ACC_W'(b);
    end
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + a_ext * b_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// R = A * B integer matrix multiplier; LANES rows of R are produced per output tile.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int M      = 3,
  parameter int K      = 3,
  parameter int N      = 3,
  parameter int LANES  = 3,
  localparam int ACC_W = acc_width(DATA_W, K),
  localparam int AA_W  = clog2_min1(M * K),
  localparam int BA_W  = clog2_min1(K * N),
  localparam int RA_W  = clog2_min1(M * N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    signed_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    a_rd_en,
  output logic [LANES*AA_W-1:0]   a_rd_addr,
  input  logic [LANES*DATA_W-1:0] a_rd_data,
  output logic                    b_rd_en,
  output logic [BA_W-1:0]         b_rd_addr,
  input  logic [DATA_W-1:0]       b_rd_data,
  output logic                    r_wr_en,
  output logic [LANES*RA_W-1:0]   r_wr_addr,
  output logic [LANES*ACC_W-1:0]  r_wr_data
);

  localparam int RG_N = M / LANES;
  localparam int RG_W = clog2_min1(RG_N);
  localparam int J_W  = clog2_min1(N);
  localparam int K_W  = clog2_min1(K);

  if (M % LANES != 0) begin : g_bad_lanes
    $error("matmul_engine: M must be a multiple of LANES");
  end
  if (K < 1) begin : g_bad_k
    $error("matmul_engine: K must be at least 1");
  end

  state_t           state_q, state_d;
  logic [RG_W-1:0]  rg_q, rg_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             signed_q, signed_d;
  logic             rd_vld_q, rd_vld_d;
  logic             done_q, done_d;
  logic             clr;
  logic [ACC_W-1:0] acc [LANES];

  always_comb begin
    state_d  = state_q;
    rg_d     = rg_q;
    j_d      = j_q;
    k_d      = k_q;
    signed_d = signed_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_RUN;
            rg_d     = '0;
            j_d      = '0;
            k_d      = '0;
            signed_d = signed_mode;
          end
        end
        S_RUN: begin
          if (k_q == K_W'(K - 1)) begin
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        S_DRAIN: state_d = S_WRITE;
        S_WRITE: begin
          k_d = '0;
          if (j_q == J_W'(N - 1)) begin
            j_d = '0;
            if (rg_q == RG_W'(RG_N - 1)) begin
              state_d = S_DONE;
            end else begin
              rg_d    = rg_q + 1'b1;
              state_d = S_RUN;
            end
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Accumulators clear on an accepted start and after every tile write, even if aborted.
  assign clr      = (state_q == S_WRITE) || (state_q == S_IDLE && start && !abort);
  assign busy     = (state_q != S_IDLE);
  assign a_rd_en  = (state_q == S_RUN);
  assign b_rd_en  = (state_q == S_RUN);
  assign r_wr_en  = (state_q == S_WRITE);
  assign done     = done_q;
  assign rd_vld_d = a_rd_en && !abort;

  always_comb begin
    a_rd_addr = '0;
    b_rd_addr = '0;
    r_wr_addr = '0;
    r_wr_data = '0;
    if (a_rd_en) begin
      b_rd_addr = BA_W'(32'(k_q) * N + 32'(j_q));
      for (int unsigned l = 0; l < LANES; l++) begin
        a_rd_addr[l*AA_W +: AA_W] = AA_W'((32'(rg_q) * LANES + l) * K + 32'(k_q));
      end
    end
    if (r_wr_en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        r_wr_addr[l*RA_W +: RA_W]   = RA_W'((32'(rg_q) * LANES + l) * N + 32'(j_q));
        r_wr_data[l*ACC_W +: ACC_W] = acc[l];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_mac (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .en         (rd_vld_q),
      .signed_mode(signed_q),
      .a          (a_rd_data[g*DATA_W +: DATA_W]),
      .b          (b_rd_data),
      .acc        (acc[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rg_q     <= '0;
      j_q      <= '0;
      k_q      <= '0;
      signed_q <= 1'b0;
      rd_vld_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rg_q     <= rg_d;
      j_q      <= j_d;
      k_q      <= k_d;
      signed_q <= signed_d;
      rd_vld_q <= rd_vld_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench: two engine configurations, memory models, reference matrix product.
module tb_matmul_engine;

  localparam int DW   = 8;
  localparam int ACC0 = 18, AA0 = 4, BA0 = 4, RA0 = 4;
  localparam int ACC1 = 19, AA1 = 5, BA1 = 4, RA1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_v = '0, abort_v = '0, sm_v = '0;
  logic [1:0] busy_v, done_v, a_en_v, b_en_v, wr_v;

  logic [3*AA0-1:0]  a_addr0;
  logic [3*DW-1:0]   a_data0 = '0;
  logic [BA0-1:0]    b_addr0;
  logic [DW-1:0]     b_data0 = '0;
  logic [3*RA0-1:0]  r_addr0;
  logic [3*ACC0-1:0] r_data0;

  logic [2*AA1-1:0]  a_addr1;
  logic [2*DW-1:0]   a_data1 = '0;
  logic [BA1-1:0]    b_addr1;
  logic [DW-1:0]     b_data1 = '0;
  logic [2*RA1-1:0]  r_addr1;
  logic [2*ACC1-1:0] r_data1;

  logic [7:0] a_mem [2][20];
  logic [7:0] b_mem [2][10];

  typedef struct {
    int unsigned     addr;
    longint unsigned data;
  } exp_t;
  exp_t sbq0[$];
  exp_t sbq1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  matmul_engine #(.DATA_W(8), .M(3), .K(3), .N(3), .LANES(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .signed_mode(sm_v[0]),
    .busy(busy_v[0]), .done(done_v[0]),
    .a_rd_en(a_en_v[0]), .a_rd_addr(a_addr0), .a_rd_data(a_data0),
    .b_rd_en(b_en_v[0]), .b_rd_addr(b_addr0), .b_rd_data(b_data0),
    .r_wr_en(wr_v[0]), .r_wr_addr(r_addr0), .r_wr_data(r_data0)
  );

  matmul_engine #(.DATA_W(8), .M(4), .K(5), .N(2), .LANES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .signed_mode(sm_v[1]),
    .busy(busy_v[1]), .done(done_v[1]),
    .a_rd_en(a_en_v[1]), .a_rd_addr(a_addr1), .a_rd_data(a_data1),
    .b_rd_en(b_en_v[1]), .b_rd_addr(b_addr1), .b_rd_data(b_data1),
    .r_wr_en(wr_v[1]), .r_wr_addr(r_addr1), .r_wr_data(r_data1)
  );

  // Synchronous-read memories: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (a_en_v[0]) for (int l = 0; l < 3; l++) a_data0[l*DW +: DW] <= a_mem[0][a_addr0[l*AA0 +: AA0]];
    if (b_en_v[0]) b_data0 <= b_mem[0][b_addr0];
    if (a_en_v[1]) for (int l = 0; l < 2; l++) a_data1[l*DW +: DW] <= a_mem[1][a_addr1[l*AA1 +: AA1]];
    if (b_en_v[1]) b_data1 <= b_mem[1][b_addr1];
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic get_dims(input int d, output int m, output int k, output int n,
                          output int lanes, output int accw);
    if (d == 0) begin m = 3; k = 3; n = 3; lanes = 3; accw = ACC0; end
    else        begin m = 4; k = 5; n = 2; lanes = 2; accw = ACC1; end
  endtask

  function automatic longint elem(input int d, input bit is_a, input int idx, input bit sm);
    logic [7:0] v;
    v = is_a ? a_mem[d][idx] : b_mem[d][idx];
    return sm ? longint'($signed(v)) : longint'(v);
  endfunction

  // Reference: plain matrix product, results queued in tile order (row group, then column).
  task automatic push_expected(input int d, input bit sm, input int tiles);
    int m, k, n, lanes, accw;
    int t;
    get_dims(d, m, k, n, lanes, accw);
    t = 0;
    for (int rg = 0; rg < m / lanes; rg++) begin
      for (int j = 0; j < n; j++) begin
        if (t < tiles) begin
          for (int l = 0; l < lanes; l++) begin
            int i;
            longint s;
            exp_t e;
            i = rg * lanes + l;
            s = 0;
            for (int kk = 0; kk < k; kk++) s += elem(d, 1'b1, i * k + kk, sm) * elem(d, 1'b0, kk * n + j, sm);
            e.addr = i * n + j;
            e.data = longint'(s) & ((64'd1 << accw) - 1);
            if (d == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
          end
        end
        t++;
      end
    end
  endtask

  task automatic check_write(input int d, input longint unsigned addr, input longint unsigned data);
    exp_t e;
    int sz;
    sz = (d == 0) ? sbq0.size() : sbq1.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_write dut%0d: got addr 0x%0h data 0x%0h, expected no write", d, addr, data);
    end else begin
      e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
      chk($sformatf("wr_addr dut%0d", d), addr, longint'(e.addr));
      chk($sformatf("wr_data dut%0d", d), data, e.data);
    end
  endtask

  // Monitor: compare every presented write against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_v[0]) begin
        wr_cnt[0]++;
        for (int l = 0; l < 3; l++) check_write(0, longint'(r_addr0[l*RA0 +: RA0]), longint'(r_data0[l*ACC0 +: ACC0]));
      end
      if (wr_v[1]) begin
        wr_cnt[1]++;
        for (int l = 0; l < 2; l++) check_write(1, longint'(r_addr1[l*RA1 +: RA1]), longint'(r_data1[l*ACC1 +: ACC1]));
      end
      if (done_v[0]) done_cnt[0]++;
      if (done_v[1]) done_cnt[1]++;
    end
  end

  task automatic run_job(input int d, input bit sm, input int exp_lat, input bit extra_starts);
    int m, k, n, lanes, accw;
    int tiles, lat, wr0, dn0, qsz;
    bit seen;
    get_dims(d, m, k, n, lanes, accw);
    tiles = (m / lanes) * n;
    lat   = 0;
    seen  = 1'b0;
    wr0   = wr_cnt[d];
    dn0   = done_cnt[d];
    push_expected(d, sm, tiles);
    @(negedge clk);
    sm_v[d]    = sm;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    sm_v[d]    = ~sm;
    while (!seen && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start_v[d] = extra_starts && (lat == 3 || lat == 11);
      if (done_v[d]) seen = 1'b1;
    end
    start_v[d] = 1'b0;
    chk($sformatf("done_seen dut%0d", d), seen, 1);
    chk($sformatf("done_latency dut%0d", d), lat, exp_lat);
    chk($sformatf("busy_at_done dut%0d", d), busy_v[d], 0);
    @(negedge clk);
    chk($sformatf("done_pulse_width dut%0d", d), done_v[d], 0);
    chk($sformatf("write_count dut%0d", d), wr_cnt[d] - wr0, tiles);
    chk($sformatf("done_count dut%0d", d), done_cnt[d] - dn0, 1);
    qsz = (d == 0) ? sbq0.size() : sbq1.size();
    chk($sformatf("scoreboard_empty dut%0d", d), qsz, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, dn0, seenw, c;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {busy_v, done_v, a_en_v, b_en_v, wr_v}, 0);
    chk("reset_addr0", {a_addr0, b_addr0, r_addr0}, 0);
    chk("reset_data0", r_data0, 0);
    chk("reset_dut1", {a_addr1, b_addr1, r_addr1, r_data1}, 0);
    rst = 1'b0;

    // T1 identity
    for (int i = 0; i < 9; i++) begin
      a_mem[0][i] = 8'(i + 1);
      b_mem[0][i] = (i % 4 == 0) ? 8'd1 : 8'd0;
    end
    run_job(0, 1'b0, 16, 1'b0);

    // T2 max unsigned
    for (int i = 0; i < 9; i++) begin a_mem[0][i] = 8'hFF; b_mem[0][i] = 8'hFF; end
    run_job(0, 1'b0, 16, 1'b1);

    // T3 signed and unsigned on the same data
    for (int i = 0; i < 9; i++) begin a_mem[0][i] = 8'hFF; b_mem[0][i] = 8'h02; end
    run_job(0, 1'b1, 16, 1'b0);
    run_job(0, 1'b0, 16, 1'b0);

    // start and abort together in IDLE: stay idle
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    @(negedge clk);
    chk("start_abort_idle_busy", busy_v[0], 0);
    chk("start_abort_idle_rd", a_en_v[0], 0);

    // T4 abort during the second tile write
    for (int i = 0; i < 9; i++) begin
      a_mem[0][i] = 8'($urandom_range(0, 255));
      b_mem[0][i] = 8'($urandom_range(0, 255));
    end
    wr0 = wr_cnt[0];
    dn0 = done_cnt[0];
    push_expected(0, 1'b0, 2);
    @(negedge clk);
    sm_v[0]    = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    seenw = 0;
    c     = 0;
    while (seenw < 2 && c < 100) begin
      @(negedge clk);
      c++;
      if (wr_v[0]) seenw++;
    end
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_v[0], 0);
    repeat (20) @(negedge clk);
    chk("abort_write_count", wr_cnt[0] - wr0, 2);
    chk("abort_done_count", done_cnt[0] - dn0, 0);
    chk("abort_scoreboard_empty", sbq0.size(), 0);

    // T5 reset mid-RUN, then a clean identity rerun
    for (int i = 0; i < 9; i++) begin
      a_mem[0][i] = 8'(i + 1);
      b_mem[0][i] = (i % 4 == 0) ? 8'd1 : 8'd0;
    end
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", busy_v[0], 1);
    rst = 1'b1;
    #1;
    chk("midrun_reset_strobes", {busy_v[0], done_v[0], a_en_v[0], b_en_v[0], wr_v[0]}, 0);
    chk("midrun_reset_addr", {a_addr0, b_addr0, r_addr0}, 0);
    chk("midrun_reset_data", r_data0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", busy_v[0], 0);
    run_job(0, 1'b0, 16, 1'b0);

    // T6 second configuration with random data, both modes, starts while busy
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 20; i++) a_mem[1][i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 10; i++) b_mem[1][i] = 8'($urandom_range(0, 255));
      run_job(1, it[0], 29, 1'b1);
    end

    // random signed job on the first configuration too
    for (int i = 0; i < 9; i++) begin
      a_mem[0][i] = 8'($urandom_range(0, 255));
      b_mem[0][i] = 8'($urandom_range(0, 255));
    end
    run_job(0, 1'b1, 16, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
